// File: rtl/mem_access.sv
// Memory-access stage: holds one EX result in a slot and runs its DMEM load/store over a req/ack port.
// The upstream pipe stalls until the access completes, then the result goes to write-back.
module mem_access #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_WORD_WIDTH = 16,
    parameter int IALU_WORD_WIDTH = 16,
    parameter int PC_WIDTH        = 12,
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_act_load_dmem,
    input  logic                       in_act_store_dmem,
    input  logic                       in_act_write_res_to_reg,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
    input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic [IALU_WORD_WIDTH-1:0] in_res,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic                       in_dmem_ack,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_rdata,
    output logic                       out_dmem_req,
    output logic                       out_dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_addr,
    output logic [DMEM_WORD_WIDTH-1:0] out_dmem_wdata,
    output logic                       out_stall,
    output logic                       out_act_write_res_to_reg,
    output logic [IALU_WORD_WIDTH-1:0] out_res,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic                       out_res_valid,
    output logic [PMEM_WORD_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [15:0]                out_stall_cnt
);

    typedef struct packed {
        logic                       ld;
        logic                       st;
        logic                       wr;
        logic [DMEM_ADDR_WIDTH-1:0] rd_addr;
        logic [DMEM_ADDR_WIDTH-1:0] wr_addr;
        logic [DMEM_WORD_WIDTH-1:0] wr_word;
        logic [PMEM_WORD_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]        pc;
        logic [IALU_WORD_WIDTH-1:0] res;
        logic [REG_IDX_WIDTH-1:0]   reg_idx;
    } slot_t;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    slot_t       slot_q, slot_d;
    state_t      state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic is_store, is_load, mem_op, stall;

    // Store wins when both op bits are set; the load bit is then ignored.
    always_comb begin
        is_store = slot_q.st;
        is_load  = slot_q.ld & ~slot_q.st;
        mem_op   = is_store | is_load;
        stall    = mem_op & ~in_dmem_ack;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_op && !in_dmem_ack) state_d = ST_WAIT;
            ST_WAIT: if (in_dmem_ack || !mem_op) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        slot_d = slot_q;
        if (!stall) begin
            slot_d.ld      = in_act_load_dmem;
            slot_d.st      = in_act_store_dmem;
            slot_d.wr      = in_act_write_res_to_reg;
            slot_d.rd_addr = in_dmem_rd_addr;
            slot_d.wr_addr = in_dmem_wr_addr;
            slot_d.wr_word = in_dmem_wr_word;
            slot_d.instr   = in_instr;
            slot_d.pc      = in_pc;
            slot_d.res     = in_res;
            slot_d.reg_idx = in_res_reg_idx;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            slot_q      <= '0;
            state_q     <= ST_IDLE;
            stall_cnt_q <= '0;
        end else begin
            slot_q      <= slot_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // DMEM fields come straight from the held slot, so they stay stable while waiting.
    always_comb begin
        out_dmem_req   = mem_op;
        out_dmem_we    = is_store;
        out_dmem_addr  = is_store ? slot_q.wr_addr : (is_load ? slot_q.rd_addr : '0);
        out_dmem_wdata = is_store ? slot_q.wr_word : '0;
        out_stall      = stall;
    end

    always_comb begin
        out_act_write_res_to_reg = slot_q.wr & ~is_store & ~stall;
        out_res_valid            = slot_q.wr & ~is_store & ~stall;
        out_res                  = (is_load && in_dmem_ack) ? in_dmem_rdata : slot_q.res;
        out_res_reg_idx          = slot_q.reg_idx;
        out_instr                = slot_q.instr;
        out_pc                   = slot_q.pc;
        out_stall_cnt            = stall_cnt_q;
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed EX ops with a write-back scoreboard and a cycle-level DMEM responder.
module tb_mem_access;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_ld, in_st, in_wr;
    logic [11:0] in_rd_addr, in_wr_addr;
    logic [15:0] in_wr_word, in_instr, in_res;
    logic [11:0] in_pc;
    logic [3:0]  in_idx;
    logic        in_ack;
    logic [15:0] in_rdata;
    logic        req, we, stall, wb_wr, res_valid;
    logic [11:0] addr, o_pc;
    logic [15:0] wdata, o_res, o_instr, stall_cnt;
    logic [3:0]  o_idx;

    int checks = 0;
    int failures = 0;

    typedef struct { logic [15:0] res; logic [3:0] idx; } wb_t;
    wb_t exp_q[$];

    always #5 clock = ~clock;

    mem_access dut (
        .clock(clock), .reset(reset),
        .in_act_load_dmem(in_ld), .in_act_store_dmem(in_st), .in_act_write_res_to_reg(in_wr),
        .in_dmem_rd_addr(in_rd_addr), .in_dmem_wr_addr(in_wr_addr), .in_dmem_wr_word(in_wr_word),
        .in_instr(in_instr), .in_pc(in_pc), .in_res(in_res), .in_res_reg_idx(in_idx),
        .in_dmem_ack(in_ack), .in_dmem_rdata(in_rdata),
        .out_dmem_req(req), .out_dmem_we(we), .out_dmem_addr(addr), .out_dmem_wdata(wdata),
        .out_stall(stall), .out_act_write_res_to_reg(wb_wr), .out_res(o_res),
        .out_res_reg_idx(o_idx), .out_res_valid(res_valid), .out_instr(o_instr), .out_pc(o_pc),
        .out_stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ex_op(input logic ld, input logic st, input logic wr, input logic [11:0] ra,
                         input logic [11:0] wa, input logic [15:0] ww, input logic [15:0] r,
                         input logic [3:0] idx);
        in_ld = ld; in_st = st; in_wr = wr; in_rd_addr = ra; in_wr_addr = wa;
        in_wr_word = ww; in_res = r; in_idx = idx; in_instr = {4'hA, ra}; in_pc = wa ^ ra;
    endtask

    task automatic ex_idle();
        ex_op(1'b0, 1'b0, 1'b0, 12'h0, 12'h0, 16'h0, 16'h0, 4'h0);
    endtask

    // Write-back monitor: every WB write must match the oldest expected entry.
    always begin
        @(negedge clock);
        #2;
        if (wb_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wb_spurious", 32'(o_res), 32'hFFFF_FFFF);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_res", 32'(o_res), 32'(e.res));
                chk("wb_idx", 32'(o_idx), 32'(e.idx));
            end
        end
    end

    initial begin
        logic [15:0] cnt0;
        logic        req_held;
        reset = 1'b0; in_ack = 1'b0; in_rdata = 16'h0;
        ex_idle();
        repeat (3) @(negedge clock);
        #1;
        chk("rst_req", 32'(req), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_wr", 32'(wb_wr), 0);
        chk("rst_res", 32'(o_res), 0);
        chk("rst_cnt", 32'(stall_cnt), 0);
        chk("rst_pc", 32'(o_pc), 0);
        reset = 1'b1;

        // ALU op, one-cycle latency
        @(negedge clock);
        ex_op(1'b0, 1'b0, 1'b1, 12'h0, 12'h0, 16'h0, 16'h1234, 4'd3);
        exp_q.push_back('{16'h1234, 4'd3});
        @(negedge clock);
        ex_idle();
        #1;
        chk("alu_res", 32'(o_res), 32'h1234);
        chk("alu_idx", 32'(o_idx), 3);
        chk("alu_wr", 32'(wb_wr), 1);
        chk("alu_valid", 32'(res_valid), 1);
        chk("alu_stall", 32'(stall), 0);

        // Load acked in the same cycle
        @(negedge clock);
        ex_op(1'b1, 1'b0, 1'b1, 12'h010, 12'h0, 16'h0, 16'hDEAD, 4'd5);
        exp_q.push_back('{16'hBEEF, 4'd5});
        @(negedge clock);
        ex_idle();
        in_ack = 1'b1; in_rdata = 16'hBEEF;
        #1;
        chk("ld_req", 32'(req), 1);
        chk("ld_we", 32'(we), 0);
        chk("ld_addr", 32'(addr), 32'h010);
        chk("ld_stall", 32'(stall), 0);
        chk("ld_res", 32'(o_res), 32'hBEEF);
        chk("ld_wr", 32'(wb_wr), 1);
        @(negedge clock);
        in_ack = 1'b0;
        #1;
        chk("ld_done_req", 32'(req), 0);

        // Store acked after three stall cycles; next op waits in EX
        @(negedge clock);
        cnt0 = stall_cnt;
        ex_op(1'b0, 1'b1, 1'b1, 12'h0, 12'h020, 16'h00AA, 16'h7777, 4'd7);
        @(negedge clock);
        ex_op(1'b0, 1'b0, 1'b1, 12'h0, 12'h0, 16'h0, 16'h5555, 4'd9);
        exp_q.push_back('{16'h5555, 4'd9});
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("st_stall", 32'(stall), 1);
            chk("st_we", 32'(we), 1);
            chk("st_addr", 32'(addr), 32'h020);
            chk("st_wdata", 32'(wdata), 32'h00AA);
            chk("st_wr", 32'(wb_wr), 0);
            @(negedge clock);
        end
        in_ack = 1'b1;
        #1;
        chk("st_ack_stall", 32'(stall), 0);
        chk("st_ack_wr", 32'(wb_wr), 0);
        chk("st_ack_valid", 32'(res_valid), 0);
        @(negedge clock);
        in_ack = 1'b0;
        ex_idle();
        #1;
        chk("st_next_res", 32'(o_res), 32'h5555);
        chk("st_next_wr", 32'(wb_wr), 1);
        chk("st_cnt", 32'(stall_cnt - cnt0), 3);

        // Reset during WAIT, late ack ignored
        @(negedge clock);
        ex_op(1'b1, 1'b0, 1'b1, 12'h040, 12'h0, 16'h0, 16'h0, 4'd2);
        @(negedge clock);
        ex_idle();
        #1;
        chk("rw_stall", 32'(stall), 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rw_req_pre", 32'(req), 1);
        @(negedge clock);
        reset = 1'b1;
        in_ack = 1'b1; in_rdata = 16'h1111;
        #1;
        chk("rw_req", 32'(req), 0);
        chk("rw_wr", 32'(wb_wr), 0);
        chk("rw_stall_post", 32'(stall), 0);
        chk("rw_cnt", 32'(stall_cnt), 0);
        @(negedge clock);
        in_ack = 1'b0;

        // Load and store both set: store only
        @(negedge clock);
        ex_op(1'b1, 1'b1, 1'b1, 12'h050, 12'h030, 16'h0C0C, 16'h0, 4'd4);
        @(negedge clock);
        ex_idle();
        in_ack = 1'b1;
        #1;
        chk("ls_req", 32'(req), 1);
        chk("ls_we", 32'(we), 1);
        chk("ls_addr", 32'(addr), 32'h030);
        chk("ls_wdata", 32'(wdata), 32'h0C0C);
        chk("ls_wr", 32'(wb_wr), 0);
        @(negedge clock);
        in_ack = 1'b0;

        // Long wait: counter saturates, request held
        @(negedge clock);
        ex_op(1'b1, 1'b0, 1'b1, 12'h060, 12'h0, 16'h0, 16'h0, 4'd6);
        @(negedge clock);
        ex_idle();
        req_held = 1'b1;
        for (int k = 0; k < 70000; k++) begin
            #1;
            if (req !== 1'b1 || addr !== 12'h060) req_held = 1'b0;
            @(negedge clock);
        end
        #1;
        chk("sat_req_held", 32'(req_held), 1);
        chk("sat_cnt", 32'(stall_cnt), 32'hFFFF);
        @(negedge clock);
        in_ack = 1'b1; in_rdata = 16'h6060;
        exp_q.push_back('{16'h6060, 4'd6});
        #1;
        chk("sat_done_res", 32'(o_res), 32'h6060);
        @(negedge clock);
        in_ack = 1'b0;
        #1;
        chk("sat_cnt_hold", 32'(stall_cnt), 32'hFFFF);
        repeat (2) @(negedge clock);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
